// File: rtl/spi_pkg.sv
// Shared constants for the SPI front end: pad idle levels and filter depth.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package spi_pkg;

    // Levels the pads are assumed to sit at while the bus is idle.
    localparam logic SCK_IDLE  = 1'b0;
    localparam logic CS_IDLE   = 1'b1;
    localparam logic MOSI_IDLE = 1'b0;

    // Consecutive clk cycles a synchronized pin must disagree with the
    // conditioned level before the conditioned level follows it.
    localparam int unsigned WAIT_DEFAULT = 3;

    // Filter counter width: wide enough to hold WAIT-1, never narrower than 1.
    function automatic int unsigned cnt_width(input int unsigned wait_cycles);
        if (wait_cycles <= 1) begin
            return 1;
        end
        return $clog2(wait_cycles);
    endfunction

endpackage

// File: rtl/signal_conditioner.sv
// One pad channel: 2-flop synchronizer, persistence glitch filter, edge pulses.
// Latency: WAIT+2 clk edges from a stable pin to cond and its pulse.
// Backpressure: none; free-running, pulses are single-cycle and never held.
module signal_conditioner
    import spi_pkg::*;
#(
    parameter int unsigned WAIT      = WAIT_DEFAULT,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic noisy,
    output logic cond,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CW       = cnt_width(WAIT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WAIT - 1);

    logic          s1_q,   s1_d;
    logic          s2_q,   s2_d;
    logic          cond_q, cond_d;
    logic [CW-1:0] cnt_q,  cnt_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;

    // Synchronizer: plain flop-to-flop chain, nothing between the stages.
    always_comb begin
        s1_d = noisy;
        s2_d = s1_q;
    end

    // Filter: count consecutive disagreements, adopt s2 once the run reaches
    // WAIT; any agreement in between discards the partial run.
    always_comb begin
        cond_d = cond_q;
        cnt_d  = '0;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s2_q == cond_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cond_d = s2_q;
            cnt_d  = '0;
            rise_d = s2_q;
            fall_d = ~s2_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State register; reset parks the channel at its idle level with no pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= RESET_VAL;
            s2_q   <= RESET_VAL;
            cond_q <= RESET_VAL;
            cnt_q  <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            cond_q <= cond_d;
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    // Everything leaving the channel comes straight from flops.
    always_comb begin
        cond = cond_q;
        rise = rise_q;
        fall = fall_q;
    end

endmodule

// File: rtl/spi_input_conditioner.sv
// Conditions raw SCK/CS/MOSI pads into clean clk-domain levels and edge pulses.
// Latency: WAIT+2 clk edges per channel from a stable pad to level and pulse.
// Backpressure: none; outputs are registered and free-running.
module spi_input_conditioner
    import spi_pkg::*;
#(
    parameter int unsigned WAIT = WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_in,
    input  logic cs_in,
    input  logic mosi_in,
    output logic sck_cond,
    output logic cs_cond,
    output logic mosi_cond,
    output logic sck_rise,
    output logic sck_fall,
    output logic cs_fall,
    output logic cs_rise
);

    // MOSI is only ever sampled as a level, so its edge pulses have no consumer.
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    signal_conditioner #(
        .WAIT      (WAIT),
        .RESET_VAL (SCK_IDLE)
    ) u_sck (
        .clk   (clk),
        .rst_n (rst_n),
        .noisy (sck_in),
        .cond  (sck_cond),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    // CS is active-low: its fall marks frame start, its rise frame end.
    signal_conditioner #(
        .WAIT      (WAIT),
        .RESET_VAL (CS_IDLE)
    ) u_cs (
        .clk   (clk),
        .rst_n (rst_n),
        .noisy (cs_in),
        .cond  (cs_cond),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    signal_conditioner #(
        .WAIT      (WAIT),
        .RESET_VAL (MOSI_IDLE)
    ) u_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .noisy (mosi_in),
        .cond  (mosi_cond),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

endmodule

// File: tb/tb_spi_input_conditioner.sv
// Scoreboard bench: a window-based reference model predicts levels and pulses,
// a negedge monitor pops and compares, directed scenarios add explicit checks.
module tb_spi_input_conditioner;
    import spi_pkg::*;

    localparam int W = WAIT_DEFAULT;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic sck_in  = SCK_IDLE;
    logic cs_in   = CS_IDLE;
    logic mosi_in = MOSI_IDLE;
    logic sck_cond, cs_cond, mosi_cond;
    logic sck_rise, sck_fall, cs_fall, cs_rise;

    spi_input_conditioner #(.WAIT(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck_in    (sck_in),
        .cs_in     (cs_in),
        .mosi_in   (mosi_in),
        .sck_cond  (sck_cond),
        .cs_cond   (cs_cond),
        .mosi_cond (mosi_cond),
        .sck_rise  (sck_rise),
        .sck_fall  (sck_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic idle_of(input int ch);
        case (ch)
            0:       return SCK_IDLE;
            1:       return CS_IDLE;
            default: return MOSI_IDLE;
        endcase
    endfunction

    // ---------------- reference model ----------------
    // A level change is predicted when the last W pin samples, each seen
    // two clk edges late, all disagree with the current level.
    typedef struct {
        int         cyc;
        logic [3:0] p;   // {sck_rise, sck_fall, cs_fall, cs_rise}
    } ev_t;

    ev_t  exp_q[$];
    int   cyc;
    logic m_cond [3];
    logic m_old1 [3];
    logic m_old2 [3];
    logic m_hist [3][W];
    logic m_pins [3];
    logic m_diff;
    logic m_d;
    logic [3:0] m_p;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cyc = 0;
                exp_q.delete();
                for (int ch = 0; ch < 3; ch++) begin
                    m_cond[ch] = idle_of(ch);
                    m_old1[ch] = idle_of(ch);
                    m_old2[ch] = idle_of(ch);
                    for (int i = 0; i < W; i++) m_hist[ch][i] = idle_of(ch);
                end
            end else begin
                cyc++;
                m_pins[0] = sck_in;
                m_pins[1] = cs_in;
                m_pins[2] = mosi_in;
                m_p = 4'b0;
                for (int ch = 0; ch < 3; ch++) begin
                    m_d        = m_old2[ch];
                    m_old2[ch] = m_old1[ch];
                    m_old1[ch] = m_pins[ch];
                    for (int i = W - 1; i > 0; i--) m_hist[ch][i] = m_hist[ch][i-1];
                    m_hist[ch][0] = m_d;
                    m_diff = 1'b1;
                    for (int i = 0; i < W; i++)
                        if (m_hist[ch][i] == m_cond[ch]) m_diff = 1'b0;
                    if (m_diff) begin
                        m_cond[ch] = ~m_cond[ch];
                        if (ch == 0) begin
                            m_p[3] = m_cond[ch];
                            m_p[2] = ~m_cond[ch];
                        end else if (ch == 1) begin
                            m_p[1] = ~m_cond[ch];
                            m_p[0] = m_cond[ch];
                        end
                    end
                end
                if (m_p != 4'b0) exp_q.push_back('{cyc, m_p});
            end
        end
    end

    // ---------------- monitor ----------------
    int   n_sck_rise = 0, n_sck_fall = 0, n_cs_fall = 0, n_cs_rise = 0;
    int   last_sck_rise = -1, last_cs_fall = -1;
    logic rise_log[$];
    ev_t  mon_e;
    logic [3:0] dut_p;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("cond_levels", {sck_cond, cs_cond, mosi_cond},
                    {m_cond[0], m_cond[1], m_cond[2]});
                dut_p = {sck_rise, sck_fall, cs_fall, cs_rise};
                if (dut_p != 4'b0) begin
                    if (exp_q.size() == 0) begin
                        chk("pulse_unexpected", dut_p, 0);
                    end else begin
                        mon_e = exp_q.pop_front();
                        chk("pulse_cycle", cyc, mon_e.cyc);
                        chk("pulse_kind", dut_p, mon_e.p);
                    end
                end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                    mon_e = exp_q.pop_front();
                    chk("pulse_missing", 0, mon_e.p);
                end
                if (sck_rise) begin
                    n_sck_rise++;
                    last_sck_rise = cyc;
                    rise_log.push_back(mosi_cond);
                end
                if (sck_fall) n_sck_fall++;
                if (cs_fall) begin
                    n_cs_fall++;
                    last_cs_fall = cyc;
                end
                if (cs_rise) n_cs_rise++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sck_cond"},  sck_cond,  SCK_IDLE);
        chk({tag, "_cs_cond"},   cs_cond,   CS_IDLE);
        chk({tag, "_mosi_cond"}, mosi_cond, MOSI_IDLE);
        chk({tag, "_pulses"},    {sck_rise, sck_fall, cs_fall, cs_rise}, 0);
    endtask

    int         t0, n0, n1, n2, n3;
    logic [7:0] data;

    initial begin
        data = 8'hA5;
        cycles(2);
        #1;
        chk_reset_outputs("reset_init");
        cycles(1);
        #2 rst_n = 1'b1;
        cycles(6);

        // Clean SCK rise: pulse exactly WAIT+2 edges after the pin moves.
        t0 = cyc; n0 = n_sck_rise;
        sck_in = 1'b1;
        cycles(10);
        chk("clean_rise_cycle", last_sck_rise, t0 + W + 2);
        chk("clean_rise_count", n_sck_rise - n0, 1);
        chk("clean_rise_level", sck_cond, 1);

        // Glitch of WAIT-1 cycles is rejected; WAIT cycles gets through.
        sck_in = 1'b0;
        cycles(10);
        n0 = n_sck_rise; n1 = n_sck_fall;
        sck_in = 1'b1;
        cycles(W - 1);
        sck_in = 1'b0;
        cycles(10);
        chk("glitch_no_rise", n_sck_rise - n0, 0);
        chk("glitch_no_fall", n_sck_fall - n1, 0);
        chk("glitch_level", sck_cond, 0);
        sck_in = 1'b1;
        cycles(W);
        sck_in = 1'b0;
        cycles(10);
        chk("pulse_wait_rise", n_sck_rise - n0, 1);
        chk("pulse_wait_fall", n_sck_fall - n1, 1);

        // Frame: 8 SCK periods, MOSI 0xA5 MSB first, changed on falling SCK.
        rise_log.delete();
        n0 = n_sck_rise; n1 = n_cs_fall; n2 = n_cs_rise;
        cs_in   = 1'b0;
        mosi_in = data[7];
        cycles(10);
        for (int b = 7; b >= 0; b--) begin
            sck_in = 1'b1;
            cycles(5);
            sck_in = 1'b0;
            if (b > 0) mosi_in = data[b-1];
            cycles(5);
        end
        cycles(5);
        cs_in = 1'b1;
        cycles(10);
        chk("frame_cs_fall", n_cs_fall - n1, 1);
        chk("frame_cs_rise", n_cs_rise - n2, 1);
        chk("frame_sck_rise", n_sck_rise - n0, 8);
        for (int i = 0; i < 8 && i < rise_log.size(); i++)
            chk("frame_mosi_bit", rise_log[i], data[7-i]);

        // CS and SCK move together: both pulses land in the same cycle.
        t0 = cyc;
        cs_in  = 1'b0;
        sck_in = 1'b1;
        cycles(10);
        chk("simul_cs_fall_cycle", last_cs_fall, t0 + W + 2);
        chk("simul_sck_rise_cycle", last_sck_rise, t0 + W + 2);

        // Mid-operation reset with CS asserted and a MOSI run in progress.
        mosi_in = 1'b1;
        cycles(3);
        #2;
        chk("pre_reset_cs_low", cs_cond, 0);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("reset_async");
        sck_in  = 1'b0;
        mosi_in = 1'b0;
        cycles(3);
        n0 = n_cs_fall; n1 = n_sck_rise; n3 = n_sck_fall;
        #2 rst_n = 1'b1;
        cycles(10);
        chk("release_cs_fall_cycle", last_cs_fall, W + 2);
        chk("release_cs_fall_count", n_cs_fall - n0, 1);
        chk("release_no_sck_pulse", (n_sck_rise - n1) + (n_sck_fall - n3), 0);

        // Random pin activity with one reset mid-stream.
        for (int k = 0; k < 3000; k++) begin
            cycles(1);
            if ($urandom_range(0, 3) == 0) sck_in  = ~sck_in;
            if ($urandom_range(0, 5) == 0) cs_in   = ~cs_in;
            if ($urandom_range(0, 2) == 0) mosi_in = ~mosi_in;
            if (k == 1500) begin
                #2 rst_n = 1'b0;
                cycles(2);
                #2 rst_n = 1'b1;
            end
        end
        cycles(20);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
